// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg -- definitions shared by the scan multiplexer, its counter
// sub-module, its bus interface and its testbench.
//   MODE_MANUAL / MODE_SCAN : encodings of the mode input
//   clog2()                 : ceiling log2 used to size channel indices
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(3) = 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_mux_if.sv
// scan_mux_if -- channel data / control / result bundle of scan_mux.
//   din    : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   sel    : manual channel select, also the scan start channel
//   mode   : MODE_MANUAL or MODE_SCAN
//   hold   : freezes outputs and scan counters
//   dout   : registered sample of the selected channel
//   ch_out : channel index of the sample in dout
//   valid  : dout holds a captured sample
// master = the side driving stimulus, slave = the multiplexer.
interface scan_mux_if
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4
) ();

  localparam int SW = clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] din;
  logic [SW-1:0]             sel;
  logic                      mode;
  logic                      hold;
  logic [WIDTH-1:0]          dout;
  logic [SW-1:0]             ch_out;
  logic                      valid;

  modport master (
    output din, sel, mode, hold,
    input  dout, ch_out, valid
  );

  modport slave (
    input  din, sel, mode, hold,
    output dout, ch_out, valid
  );

endinterface

// File: rtl/scan_mux_ctr.sv
// scan_ctr -- channel and dwell counters for the auto-scan mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : an unheld scan-mode edge; the counters advance
//   i_load     : this edge is a manual->scan transition; start at i_sel
//   i_sel      : start channel, already clamped into 0..CHANNELS-1
//   o_cur      : channel to sample on this edge (combinational)
// The registers hold the position of the NEXT sample, so a load edge
// samples i_sel directly and leaves the counters one step past it.
module scan_ctr
  import scan_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic                      i_load,
  input  logic [clog2(CHANNELS)-1:0] i_sel,
  output logic [clog2(CHANNELS)-1:0] o_cur
);

  localparam int SW  = clog2(CHANNELS);
  // DWELL=1 needs no dwell bits, but keep one so the vector is legal.
  localparam int DWW = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [SW-1:0]  CH_LAST    = SW'(CHANNELS - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);

  logic [SW-1:0]  r_cur;
  logic [DWW-1:0] r_dwell;
  logic [SW-1:0]  w_cur;
  logic [DWW-1:0] w_dwell;

  // A load replaces the stored position for this edge's sample.
  assign w_cur   = i_load ? i_sel : r_cur;
  assign w_dwell = i_load ? '0 : r_dwell;
  assign o_cur   = w_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur   <= '0;
      r_dwell <= '0;
    end else if (i_en) begin
      if (w_dwell == DWELL_LAST) begin
        r_dwell <= '0;
        // Explicit wrap so non-power-of-2 channel counts skip unused indices.
        r_cur   <= (w_cur == CH_LAST) ? '0 : w_cur + SW'(1);
      end else begin
        r_dwell <= w_dwell + DWW'(1);
        r_cur   <= w_cur;
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// scan_mux -- registered channel multiplexer with manual and auto-scan modes.
//   clk, rst_n : clock, asynchronous active-low reset (externally synchronised)
//   bus        : scan_mux_if slave (din, sel, mode, hold in; dout, ch_out, valid out)
// Manual mode samples channel sel (channel 0 if sel is out of range) every
// unheld cycle. Scan mode walks the channels, staying DWELL cycles on each,
// starting from sel on each manual->scan transition.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1
) (
  input logic        clk,
  input logic        rst_n,
  scan_mux_if.slave  bus
);

  localparam int SW = clog2(CHANNELS);

  logic [WIDTH-1:0] r_dout;
  logic [SW-1:0]    r_ch;
  logic             r_valid;
  // Mode seen at the last unheld edge; resets to manual so that scan mode
  // present at reset release behaves as a fresh transition.
  logic             r_mode_prev;

  logic [SW-1:0]    w_sel;
  logic             w_scan;
  logic             w_load;
  logic [SW-1:0]    w_scan_cur;
  logic [SW-1:0]    w_ch;
  logic [WIDTH-1:0] w_data;

  assign w_sel  = (int'(bus.sel) < CHANNELS) ? bus.sel : '0;
  assign w_scan = (bus.mode == MODE_SCAN);
  assign w_load = w_scan && (r_mode_prev == MODE_MANUAL);

  scan_ctr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_scan && !bus.hold),
    .i_load (w_load),
    .i_sel  (w_sel),
    .o_cur  (w_scan_cur)
  );

  assign w_ch   = w_scan ? w_scan_cur : w_sel;
  assign w_data = bus.din[int'(w_ch)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= '0;
      r_ch        <= '0;
      r_valid     <= 1'b0;
      r_mode_prev <= MODE_MANUAL;
    end else if (!bus.hold) begin
      r_dout      <= w_data;
      r_ch        <= w_ch;
      r_valid     <= 1'b1;
      r_mode_prev <= bus.mode;
    end
  end

  assign bus.dout   = r_dout;
  assign bus.ch_out = r_ch;
  assign bus.valid  = r_valid;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux -- self-checking bench for scan_mux. Two instances run side by
// side from shared stimulus: A (WIDTH=4, CHANNELS=4, DWELL=2) and
// B (WIDTH=4, CHANNELS=3, DWELL=1). A sample-count reference model predicts
// every output after every edge; directed sequences add fixed expectations.
module tb_scan_mux;
  import scan_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din;
  logic [1:0]  sel;
  logic        mode;
  logic        hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_mux_if #(.WIDTH(4), .CHANNELS(4)) bus_a ();
  scan_mux_if #(.WIDTH(4), .CHANNELS(3)) bus_b ();

  assign bus_a.din  = din;
  assign bus_a.sel  = sel;
  assign bus_a.mode = mode;
  assign bus_a.hold = hold;
  assign bus_b.din  = din[11:0];
  assign bus_b.sel  = sel;
  assign bus_b.mode = mode;
  assign bus_b.hold = hold;

  scan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Reference model: a scan run is "start channel + number of samples taken".
  localparam int CH_N[2] = '{4, 3};
  localparam int DW_N[2] = '{2, 1};
  int m_dout[2];
  int m_ch[2];
  int m_valid[2];
  int m_prev[2];
  int m_start[2];
  int m_n[2];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_dout[d] = 0; m_ch[d] = 0; m_valid[d] = 0;
      m_prev[d] = 0; m_start[d] = 0; m_n[d] = 0;
    end
  endtask

  task automatic model_edge();
    int s, c;
    if (!hold) begin
      for (int d = 0; d < 2; d++) begin
        s = (int'(sel) < CH_N[d]) ? int'(sel) : 0;
        if (mode == MODE_SCAN) begin
          if (m_prev[d] == 0) begin
            m_start[d] = s;
            m_n[d] = 0;
          end
          c = (m_start[d] + m_n[d] / DW_N[d]) % CH_N[d];
          m_n[d]++;
        end else begin
          c = s;
        end
        m_dout[d]  = int'((din >> (c * 4)) & 16'hF);
        m_ch[d]    = c;
        m_valid[d] = 1;
        m_prev[d]  = int'(mode);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("A_dout",  int'(bus_a.dout),   m_dout[0]);
    check_eq("A_ch",    int'(bus_a.ch_out), m_ch[0]);
    check_eq("A_valid", int'(bus_a.valid),  m_valid[0]);
    check_eq("B_dout",  int'(bus_b.dout),   m_dout[1]);
    check_eq("B_ch",    int'(bus_b.ch_out), m_ch[1]);
    check_eq("B_valid", int'(bus_b.valid),  m_valid[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Reset pulse placed between edges; called just after an edge.
  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst_n = 1'b1;
  endtask

  int seq_ch[12]   = '{2, 2, 3, 3, 3, 3, 3, 0, 0, 1, 1, 2};
  int seq_hold[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    din = '0; sel = '0; mode = MODE_MANUAL; hold = 1'b0;
    model_reset();
    #12;
    compare_all();                       // reset state
    #1 rst_n = 1'b1;

    // Manual mode stepping through all channels.
    din = 16'hDCBA;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      check_eq("man_dout", int'(bus_a.dout), 10 + i);
      check_eq("man_ch", int'(bus_a.ch_out), i);
      check_eq("man_valid", int'(bus_a.valid), 1);
    end

    // Scan from channel 2 with a 3-cycle hold mid-dwell on channel 3.
    sel = 2'd2; mode = MODE_SCAN;
    for (int i = 0; i < 12; i++) begin
      hold = seq_hold[i][0];
      step();
      check_eq("scan_seq", int'(bus_a.ch_out), seq_ch[i]);
      din = 16'($urandom);
      sel = 2'($urandom_range(0, 3));
    end
    hold = 1'b0;

    // Asynchronous reset mid-scan, then restart from sel.
    sel = 2'd1;
    async_reset_pulse();
    check_eq("rst_ch", int'(bus_a.ch_out), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("restart_seq", int'(bus_a.ch_out), 1 + i / 2);
    end

    // Three channels, DWELL=1: never visits index 3.
    mode = MODE_MANUAL; sel = 2'd0;
    step();
    mode = MODE_SCAN;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("b_scan_seq", int'(bus_b.ch_out), i % 3);
    end
    mode = MODE_MANUAL; sel = 2'd3;
    step();
    check_eq("b_sel_oor", int'(bus_b.ch_out), 0);
    check_eq("a_sel3", int'(bus_a.ch_out), 3);

    // scan->manual together with hold: frozen, then manual on next free edge.
    mode = MODE_SCAN; sel = 2'd1;
    step();
    step();
    mode = MODE_MANUAL; hold = 1'b1; sel = 2'd2;
    step();
    check_eq("bnd_frozen", int'(bus_a.ch_out), 1);
    hold = 1'b0;
    step();
    check_eq("bnd_manual", int'(bus_a.ch_out), 2);

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      din  = 16'($urandom);
      sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      hold = ($urandom_range(0, 4) == 0);
      step();
      if ($urandom_range(0, 99) == 0) async_reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
